// File: rtl/waveform_i2s_tx.sv
// Serializes the synth core's offset-binary mono sample into a Philips I2S stream.
// One sample is latched per frame and sent, in two's complement, in both slots.
module waveform_i2s_tx #(
    parameter int DATA_WIDTH = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Enable,
    input  logic [DATA_WIDTH-1:0] Waveform,
    output logic                  BitClock,
    output logic                  WordSelect,
    output logic                  SerialData,
    output logic                  SampleTaken
);

    // state | meaning
    // IDLE  | outputs parked low, waiting for Enable
    // RUN   | streaming, Hold reloads at every frame wrap
    // DRAIN | Enable dropped, finishing the current frame then parking

    localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]            state;
    logic [DIV_W-1:0]      div;
    logic [BIT_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] hold;

    logic [DATA_WIDTH-1:0] load_val;
    logic [BIT_W-1:0]      next_bit;
    logic                  fall;
    logic                  wrap;
    logic                  sd_next;
    logic                  ws_next;
    int                    nb;
    int                    slot;

    always_comb begin
        load_val = Waveform ^ {1'b1, {(DATA_WIDTH-1){1'b0}}};
        fall     = (state != IDLE) && (div == DIV_LAST) && BitClock;
        next_bit = (bit_idx == BIT_LAST) ? '0 : bit_idx + 1'b1;
        wrap     = fall && (bit_idx == BIT_LAST);
        nb       = int'(next_bit);
        slot     = nb % SLOT_WIDTH;
        // WordSelect leads the slot boundary by one bit (Philips framing)
        ws_next  = (nb >= SLOT_WIDTH - 1) && (nb <= 2 * SLOT_WIDTH - 2);
        sd_next  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (slot == DATA_WIDTH - 1 - i) begin
                sd_next = wrap ? load_val[i] : hold[i];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            div         <= '0;
            bit_idx     <= '0;
            hold        <= '0;
            BitClock    <= 1'b0;
            WordSelect  <= 1'b0;
            SerialData  <= 1'b0;
            SampleTaken <= 1'b0;
        end else begin
            SampleTaken <= 1'b0;
            case (state)
                IDLE: begin
                    if (Enable) begin
                        state       <= RUN;
                        hold        <= load_val;
                        div         <= '0;
                        bit_idx     <= '0;
                        BitClock    <= 1'b0;
                        SampleTaken <= 1'b1;
                        SerialData  <= load_val[DATA_WIDTH-1];
                        WordSelect  <= 1'b0;
                    end
                end
                RUN, DRAIN: begin
                    state <= Enable ? RUN : DRAIN;
                    if (div == DIV_LAST) begin
                        div      <= '0;
                        BitClock <= ~BitClock;
                    end else begin
                        div <= div + 1'b1;
                    end
                    if (fall) begin
                        if (wrap && (state == DRAIN)) begin
                            state      <= IDLE;
                            div        <= '0;
                            bit_idx    <= '0;
                            BitClock   <= 1'b0;
                            SerialData <= 1'b0;
                            WordSelect <= 1'b0;
                        end else begin
                            bit_idx    <= next_bit;
                            SerialData <= sd_next;
                            WordSelect <= ws_next;
                            if (wrap) begin
                                hold        <= load_val;
                                SampleTaken <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/waveform_i2s_tx.md
# waveform_i2s_tx

Serializes the synth core's 24-bit `Waveform` output into a standard Philips I2S stream for an external audio DAC. It sits directly downstream of `TopLevel`, which produces one mono sample per system clock. It decimates that stream by latching one sample per I2S frame, converts it from offset-binary to two's complement, and sends the same value in both the left and right slots. It generates its own bit clock and word-select from the system clock.

## Interface

- `DATA_WIDTH`, default 24: sample width. Must be ≤ `SLOT_WIDTH`.
- `SLOT_WIDTH`, default 32: bit clocks per channel slot. A frame is 2·`SLOT_WIDTH` bit clocks.
- `BCLK_DIV`, default 4: system clocks per `BitClock` half-period. Must be ≥ 1.

- `Clock` in 1: system clock, rising-edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Enable` in 1: request streaming. Sampled synchronously.
- `Waveform` in `DATA_WIDTH`: unsigned offset-binary sample from `TopLevel` (0 = most negative).
- `BitClock` out 1: I2S BCLK.
- `WordSelect` out 1: I2S LRCLK. 0 = left, 1 = right.
- `SerialData` out 1: I2S SD, MSB first.
- `SampleTaken` out 1: one-cycle pulse on the cycle a new sample appears in the hold register.

## Operation

- **Registers:** `State` ∈ {IDLE, RUN, DRAIN}, divider counter `Div` (0..`BCLK_DIV`-1), bit index `Bit` (0..2·`SLOT_WIDTH`-1), hold register `Hold[DATA_WIDTH]`.
- **Reset:** all outputs 0, `State`=IDLE, `Div`=0, `Bit`=0, `Hold`=0.
- **IDLE:**
  - All outputs held at 0. `Div` and `Bit` held at 0.
  - When `Enable`=1: go to RUN. Load `Hold` ← `Waveform` with MSB inverted. Set `Bit`=0, pulse `SampleTaken`, drive `SerialData` = `Hold` MSB and `WordSelect`=0.
- **RUN / DRAIN divider:**
  - `Div` increments every clock.
  - At `Div`=`BCLK_DIV`-1: `Div`←0 and `BitClock` toggles.
  - A *fall event* is a toggle where `BitClock` goes 1→0.
- **On each fall event:**
  - `Bit` ← `Bit`+1, wrapping 2·`SLOT_WIDTH`-1 → 0.
  - `SerialData` and `WordSelect` update in the same cycle from the new `Bit` value.
- **Slot mapping**, with s = `Bit` mod `SLOT_WIDTH`:
  - `SerialData` = `Hold[DATA_WIDTH-1-s]` for s < `DATA_WIDTH`, else 0.
  - Both slots use the same `Hold` (mono duplicate).
- **WordSelect:** 1 for `Bit` in `SLOT_WIDTH`-1 .. 2·`SLOT_WIDTH`-2, else 0. This is the I2S one-bit-early transition.
- **Frame wrap** (fall event entering `Bit`=0):
  - In RUN: reload `Hold` from `Waveform` (MSB inverted) and pulse `SampleTaken`.
  - In DRAIN: go to IDLE instead. All outputs are 0 the next cycle and there is no `SampleTaken`.
- **RUN → DRAIN:** when `Enable`=0. The frame in progress completes unchanged.
- **DRAIN → RUN:** when `Enable`=1 before the wrap. Streaming continues with no gap.
- **Mid-frame input changes:** changes on `Waveform` are ignored until the next wrap. `Hold` changes only at a wrap or on IDLE exit.

## Timing

- Bit clock period is 2·`BCLK_DIV` clocks with exactly 50% duty. The first rise comes `BCLK_DIV` clocks after IDLE exit.
- Frame period is 4·`SLOT_WIDTH`·`BCLK_DIV` clocks: 512 with defaults, 128 with `BCLK_DIV`=1. `SampleTaken` pulses at exactly this period while in RUN.
- `SerialData` and `WordSelect` change only in the cycle `BitClock` falls, so they are stable across every `BitClock` rising edge.
- Input-to-output latency: `Waveform` is sampled at the clock edge that sets `SampleTaken`. Its MSB is on `SerialData` in that same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Asynchronous `Reset` assertion mid-frame forces all outputs to 0 immediately. Release is synchronous to `Clock`, and the block restarts from IDLE.

## Test plan

- **Reset mid-stream:** `BCLK_DIV`=1, `Enable`=1, `Waveform`=24'hFFFFFF, assert `Reset`=0 at `Bit`=40 → all outputs 0 within the same cycle. After release with `Enable`=1, first `SampleTaken` comes 1 clock later.
- **Full-scale positive:** `Waveform`=24'hFFFFFF → `Hold`=24'h7FFFFF. `SerialData` per slot: bit 0 = 0, bits 1–23 = 1, bits 24–31 = 0, identical in the right slot. `WordSelect` is low for `Bit` 0–30 and 63, high for `Bit` 31–62.
- **Full-scale negative:** `Waveform`=24'h000000 → `SerialData` = 1 then 23 zeros then 8 zeros, in each slot. `Waveform`=24'h800000 → all zeros.
- **Mid-frame input change:** change `Waveform` from 24'h123456 to 24'hABCDEF at `Bit`=5 → the current frame still shows 24'h923456. The next frame shows 24'h2BCDEF. `SampleTaken` spacing is exactly 128 clocks.
- **Enable drop and re-enable:** drop `Enable` at `Bit`=10 → the frame runs through `Bit`=63, then IDLE with outputs 0 and no further `SampleTaken`. Separately, drop `Enable` at `Bit`=10 and re-raise it at `Bit`=50 → the wrap produces a normal `SampleTaken` with no gap.
- **Divider check:** `BCLK_DIV`=4 → `BitClock` high for 4 clocks and low for 4. `SampleTaken` period is 512 clocks. `SerialData` never changes in a `BitClock` rising-edge cycle.
